// File: rtl/user_command_encoder.sv
// Host-side initiator for the serial memory-access protocol: serializes a read/write
// request onto a UART byte stream, then streams write payload or collects read payload.
module user_command_encoder #(
  parameter logic [23:0] TIMEOUT_CYCLES = 24'd12000000,
  parameter logic [15:0] WR_GAP         = 16'd256
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic        cmd_write,
  input  logic [23:0] cmd_len,
  input  logic [31:0] cmd_addr,
  input  logic [7:0]  wr_data,
  input  logic        wr_valid,
  output logic        wr_ready,
  output logic [7:0]  rd_data,
  output logic        rd_strobe,
  output logic [7:0]  uart_txd,
  output logic        uart_txd_strobe,
  input  logic        uart_txd_ready,
  input  logic [7:0]  uart_rxd,
  input  logic        uart_rxd_strobe,
  output logic        busy,
  output logic        done,
  output logic        error
);

  typedef enum logic [3:0] {
    IDLE, HDR, OP, L2, L1, L0, A3, A2, A1, A0, WDATA, WGAP, WACK, RDATA
  } state_t;

  state_t      state_q, state_d;
  logic        write_q, write_d;
  logic [23:0] len_q, len_d;
  logic [31:0] addr_q, addr_d;
  logic [23:0] count_q, count_d;
  logic [15:0] gap_q, gap_d;
  logic [23:0] timeout_q, timeout_d;
  logic        tx_prev_q, tx_prev_d;
  logic        cmd_ready_q, cmd_ready_d;
  logic        busy_q, busy_d;
  logic        done_q, done_d;
  logic        error_q, error_d;
  logic [7:0]  rd_data_q, rd_data_d;
  logic        rd_strobe_q, rd_strobe_d;

  logic        can_tx;
  logic        tx_fire;
  logic [7:0]  tx_byte;
  logic        wr_take;
  logic [7:0]  hdr_byte;
  state_t      hdr_next;
  logic [23:0] timeout_inc;
  logic        timed_out;
  logic [16:0] gap_inc;
  logic        gap_end;

  // Transmit rule: UART ready and no strobe last cycle; reset silences the link at once.
  assign can_tx      = uart_txd_ready && !tx_prev_q && !reset;
  assign timeout_inc = timeout_q + 24'd1;
  assign timed_out   = timeout_inc >= TIMEOUT_CYCLES;
  assign gap_inc     = {1'b0, gap_q} + 17'd1;
  assign gap_end     = gap_inc >= {1'b0, WR_GAP};

  always_comb begin
    hdr_byte = 8'h00;
    hdr_next = IDLE;
    case (state_q)
      HDR: begin hdr_byte = 8'h21;                     hdr_next = OP; end
      OP:  begin hdr_byte = write_q ? 8'h57 : 8'h52;   hdr_next = L2; end
      L2:  begin hdr_byte = len_q[23:16];              hdr_next = L1; end
      L1:  begin hdr_byte = len_q[15:8];               hdr_next = L0; end
      L0:  begin hdr_byte = len_q[7:0];                hdr_next = A3; end
      A3:  begin hdr_byte = addr_q[31:24];             hdr_next = A2; end
      A2:  begin hdr_byte = addr_q[23:16];             hdr_next = A1; end
      A1:  begin hdr_byte = addr_q[15:8];              hdr_next = A0; end
      A0: begin
        hdr_byte = addr_q[7:0];
        if (write_q) hdr_next = (len_q == 24'd0) ? WACK : WDATA;
        else         hdr_next = (len_q == 24'd0) ? IDLE : RDATA;
      end
      default: begin hdr_byte = 8'h00; hdr_next = IDLE; end
    endcase
  end

  always_comb begin
    state_d     = state_q;
    write_d     = write_q;
    len_d       = len_q;
    addr_d      = addr_q;
    count_d     = count_q;
    gap_d       = gap_q;
    timeout_d   = timeout_q;
    rd_data_d   = rd_data_q;
    rd_strobe_d = 1'b0;
    done_d      = 1'b0;
    error_d     = 1'b0;
    tx_fire     = 1'b0;
    tx_byte     = 8'h00;
    wr_take     = 1'b0;

    case (state_q)
      IDLE: begin
        if (cmd_valid && cmd_ready_q) begin
          write_d = cmd_write;
          len_d   = cmd_len;
          addr_d  = cmd_addr;
          count_d = cmd_len;
          state_d = HDR;
        end
      end
      HDR, OP, L2, L1, L0, A3, A2, A1: begin
        if (can_tx) begin
          tx_fire = 1'b1;
          tx_byte = hdr_byte;
          state_d = hdr_next;
        end
      end
      A0: begin
        if (can_tx) begin
          tx_fire   = 1'b1;
          tx_byte   = hdr_byte;
          state_d   = hdr_next;
          timeout_d = 24'd0;
          done_d    = !write_q && (len_q == 24'd0);
        end
      end
      // Any byte from the far end while payload is still flowing means it gave up.
      WDATA: begin
        if (uart_rxd_strobe) begin
          error_d = 1'b1;
          state_d = IDLE;
        end else if (wr_valid && can_tx) begin
          tx_fire = 1'b1;
          tx_byte = wr_data;
          wr_take = 1'b1;
          count_d = count_q - 24'd1;
          gap_d   = 16'd0;
          state_d = WGAP;
        end
      end
      WGAP: begin
        if (uart_rxd_strobe) begin
          error_d = 1'b1;
          state_d = IDLE;
        end else if (gap_end) begin
          state_d   = (count_q == 24'd0) ? WACK : WDATA;
          timeout_d = 24'd0;
        end else begin
          gap_d = gap_inc[15:0];
        end
      end
      WACK: begin
        if (uart_rxd_strobe) begin
          done_d  = (uart_rxd == 8'h77);
          error_d = (uart_rxd != 8'h77);
          state_d = IDLE;
        end else if (timed_out) begin
          error_d = 1'b1;
          state_d = IDLE;
        end else begin
          timeout_d = timeout_inc;
        end
      end
      RDATA: begin
        if (uart_rxd_strobe) begin
          rd_data_d   = uart_rxd;
          rd_strobe_d = 1'b1;
          count_d     = count_q - 24'd1;
          timeout_d   = 24'd0;
          if (count_q == 24'd1) begin
            done_d  = 1'b1;
            state_d = IDLE;
          end
        end else if (timed_out) begin
          error_d = 1'b1;
          state_d = IDLE;
        end else begin
          timeout_d = timeout_inc;
        end
      end
      default: state_d = IDLE;
    endcase

    tx_prev_d   = tx_fire;
    cmd_ready_d = (state_d == IDLE);
    busy_d      = (state_d != IDLE);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= IDLE;
      write_q     <= 1'b0;
      len_q       <= 24'd0;
      addr_q      <= 32'd0;
      count_q     <= 24'd0;
      gap_q       <= 16'd0;
      timeout_q   <= 24'd0;
      tx_prev_q   <= 1'b0;
      cmd_ready_q <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      error_q     <= 1'b0;
      rd_data_q   <= 8'h00;
      rd_strobe_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      write_q     <= write_d;
      len_q       <= len_d;
      addr_q      <= addr_d;
      count_q     <= count_d;
      gap_q       <= gap_d;
      timeout_q   <= timeout_d;
      tx_prev_q   <= tx_prev_d;
      cmd_ready_q <= cmd_ready_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      error_q     <= error_d;
      rd_data_q   <= rd_data_d;
      rd_strobe_q <= rd_strobe_d;
    end
  end

  assign cmd_ready       = cmd_ready_q;
  assign busy            = busy_q;
  assign done            = done_q;
  assign error           = error_q;
  assign rd_data         = rd_data_q;
  assign rd_strobe       = rd_strobe_q;
  assign uart_txd        = tx_byte;
  assign uart_txd_strobe = tx_fire;
  assign wr_ready        = wr_take;

endmodule

// File: tb/tb_user_command_encoder.sv
// Directed bench for user_command_encoder: expected tx/rd bytes are queued when stimulus
// is driven and popped by a negedge monitor when the DUT produces them.
module tb_user_command_encoder;

  localparam int TIMEOUT = 200;
  localparam int GAP     = 8;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        cmd_valid = 1'b0;
  logic        cmd_ready;
  logic        cmd_write = 1'b0;
  logic [23:0] cmd_len = 24'd0;
  logic [31:0] cmd_addr = 32'd0;
  logic [7:0]  wr_data = 8'h00;
  logic        wr_valid = 1'b0;
  logic        wr_ready;
  logic [7:0]  rd_data;
  logic        rd_strobe;
  logic [7:0]  uart_txd;
  logic        uart_txd_strobe;
  logic        uart_txd_ready = 1'b1;
  logic [7:0]  uart_rxd = 8'h00;
  logic        uart_rxd_strobe = 1'b0;
  logic        busy;
  logic        done;
  logic        error;

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  int tx_count = 0;
  int term_count = 0;
  int last_tx_cyc = 0;
  int last_rd_cyc = 0;
  int term_cyc = 0;
  logic prev_strobe = 1'b0;
  logic [7:0] tx_exp[$];
  logic [7:0] rd_exp[$];
  logic [7:0] mon_b;

  user_command_encoder #(
    .TIMEOUT_CYCLES(24'(TIMEOUT)),
    .WR_GAP        (16'(GAP))
  ) dut (
    .clk            (clk),
    .reset          (reset),
    .cmd_valid      (cmd_valid),
    .cmd_ready      (cmd_ready),
    .cmd_write      (cmd_write),
    .cmd_len        (cmd_len),
    .cmd_addr       (cmd_addr),
    .wr_data        (wr_data),
    .wr_valid       (wr_valid),
    .wr_ready       (wr_ready),
    .rd_data        (rd_data),
    .rd_strobe      (rd_strobe),
    .uart_txd       (uart_txd),
    .uart_txd_strobe(uart_txd_strobe),
    .uart_txd_ready (uart_txd_ready),
    .uart_rxd       (uart_rxd),
    .uart_rxd_strobe(uart_rxd_strobe),
    .busy           (busy),
    .done           (done),
    .error          (error)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #300000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    assert (observed === expected)
    else begin
      failures++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  // Scoreboard side: every transmitted byte and every read byte is popped and compared here.
  always @(negedge clk) begin
    if (uart_txd_strobe === 1'b1) begin
      checkOutput("tx_ready_rule", uart_txd_ready, 1);
      checkOutput("tx_no_back_to_back", prev_strobe, 0);
      checkOutput("tx_expected", tx_exp.size() > 0, 1);
      if (tx_exp.size() > 0) begin
        mon_b = tx_exp.pop_front();
        checkOutput("tx_byte", uart_txd, mon_b);
      end
      tx_count++;
      last_tx_cyc = cyc;
    end
    prev_strobe = uart_txd_strobe;
    if (rd_strobe === 1'b1) begin
      checkOutput("rd_expected", rd_exp.size() > 0, 1);
      if (rd_exp.size() > 0) begin
        mon_b = rd_exp.pop_front();
        checkOutput("rd_byte", rd_data, mon_b);
      end
      last_rd_cyc = cyc;
    end
    if (done === 1'b1 || error === 1'b1) begin
      checkOutput("done_error_exclusive", done & error, 0);
      term_count++;
    end
  end

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic applyStimulus(input bit wr, input logic [23:0] len, input logic [31:0] addr);
    int n = 0;
    while (cmd_ready !== 1'b1 && n < 50) begin tick(); n++; end
    checkOutput("cmd_ready_before_accept", cmd_ready, 1);
    tx_exp.push_back(8'h21);
    tx_exp.push_back(wr ? 8'h57 : 8'h52);
    tx_exp.push_back(len[23:16]);
    tx_exp.push_back(len[15:8]);
    tx_exp.push_back(len[7:0]);
    tx_exp.push_back(addr[31:24]);
    tx_exp.push_back(addr[23:16]);
    tx_exp.push_back(addr[15:8]);
    tx_exp.push_back(addr[7:0]);
    cmd_valid = 1'b1;
    cmd_write = wr;
    cmd_len   = len;
    cmd_addr  = addr;
    tick();
    cmd_valid = 1'b0;
  endtask

  task automatic send_rx(input logic [7:0] b, input bit expect_rd);
    if (expect_rd) rd_exp.push_back(b);
    uart_rxd        = b;
    uart_rxd_strobe = 1'b1;
    tick();
    uart_rxd_strobe = 1'b0;
  endtask

  task automatic wait_tx_drain(input string tag, input int budget);
    int n = 0;
    while (tx_exp.size() != 0 && n < budget) begin tick(); n++; end
    checkOutput(tag, tx_exp.size(), 0);
  endtask

  task automatic wait_wr_ready(input string tag, input int budget, output int at_cyc);
    int n = 0;
    @(negedge clk);
    while (wr_ready !== 1'b1 && n < budget) begin @(negedge clk); n++; end
    checkOutput({tag, "_wr_ready"}, wr_ready, 1);
    checkOutput({tag, "_with_strobe"}, uart_txd_strobe, 1);
    at_cyc = cyc;
    tick();
  endtask

  task automatic wait_term(input string tag, input int budget, input logic exp_done);
    int n = 0;
    @(negedge clk);
    while (!(done === 1'b1 || error === 1'b1) && n < budget) begin @(negedge clk); n++; end
    checkOutput({tag, "_done"}, done, exp_done);
    checkOutput({tag, "_error"}, error, !exp_done);
    term_cyc = cyc;
    @(negedge clk);
    checkOutput({tag, "_cmd_ready"}, cmd_ready, 1);
    checkOutput({tag, "_busy"}, busy, 0);
    tick();
  endtask

  initial begin
    int w1, w2, base, n, saved_tx, saved_term;

    repeat (3) tick();
    @(negedge clk);
    checkOutput("rst_cmd_ready", cmd_ready, 0);
    checkOutput("rst_busy", busy, 0);
    checkOutput("rst_done", done, 0);
    checkOutput("rst_error", error, 0);
    checkOutput("rst_rd_data", rd_data, 0);
    checkOutput("rst_txd_strobe", uart_txd_strobe, 0);
    tick();
    reset = 1'b0;
    tick();
    @(negedge clk);
    checkOutput("cmd_ready_after_reset", cmd_ready, 1);
    tick();

    $display("[TB] read len 3");
    applyStimulus(1'b0, 24'd3, 32'h0001_2345);
    @(negedge clk);
    checkOutput("first_hdr_latency", uart_txd_strobe, 1);
    checkOutput("busy_after_accept", busy, 1);
    tick();
    wait_tx_drain("read_hdr_drain", 40);
    send_rx(8'hAA, 1'b1); tick(); tick();
    send_rx(8'hBB, 1'b1); tick();
    send_rx(8'hCC, 1'b1);
    wait_term("read3", 5, 1'b1);
    checkOutput("read3_done_with_last_rd", term_cyc, last_rd_cyc);

    $display("[TB] write len 2");
    wr_data  = 8'h5A;
    wr_valid = 1'b1;
    applyStimulus(1'b1, 24'd2, 32'h0000_0010);
    tx_exp.push_back(8'h5A);
    wait_wr_ready("wr_p0", 60, w1);
    wr_data = 8'hA5;
    tx_exp.push_back(8'hA5);
    wait_wr_ready("wr_p1", GAP + 20, w2);
    wr_valid = 1'b0;
    checkOutput("wr_payload_gap", (w2 - w1) >= GAP, 1);
    repeat (GAP + 4) tick();
    send_rx(8'h77, 1'b0);
    wait_term("write2", 5, 1'b1);

    $display("[TB] write abort");
    wr_data  = 8'h11;
    wr_valid = 1'b1;
    applyStimulus(1'b1, 24'd2, 32'h0000_0200);
    tx_exp.push_back(8'h11);
    wait_wr_ready("abort_p0", 60, w1);
    wr_data  = 8'h22;
    saved_tx = tx_count;
    tick();
    send_rx(8'h25, 1'b0);
    wait_term("write_abort", 5, 1'b0);
    repeat (2 * GAP) tick();
    wr_valid = 1'b0;
    checkOutput("abort_no_more_tx", tx_count, saved_tx);

    $display("[TB] read timeout");
    applyStimulus(1'b0, 24'd4, 32'h0000_0400);
    wait_tx_drain("timeout_hdr_drain", 40);
    send_rx(8'h01, 1'b1); tick();
    send_rx(8'h02, 1'b1);
    wait_term("timeout", TIMEOUT + 20, 1'b0);
    checkOutput("timeout_latency", term_cyc - last_rd_cyc, TIMEOUT);

    $display("[TB] zero-length requests");
    applyStimulus(1'b0, 24'd0, 32'h0000_0800);
    wait_term("read0", 40, 1'b1);
    checkOutput("read0_hdr_sent", tx_exp.size(), 0);
    checkOutput("read0_done_after_last_tx", term_cyc - last_tx_cyc, 1);
    applyStimulus(1'b1, 24'd0, 32'h00AB_CDEF);
    wait_tx_drain("write0_hdr_drain", 40);
    tick(); tick(); tick();
    send_rx(8'h77, 1'b0);
    wait_term("write0", 5, 1'b1);
    applyStimulus(1'b1, 24'd0, 32'h0000_0C00);
    wait_tx_drain("write0_nak_drain", 40);
    send_rx(8'h3F, 1'b0);
    wait_term("write0_nak", 5, 1'b0);

    $display("[TB] ready stall then reset in header");
    base = tx_count;
    applyStimulus(1'b0, 24'd5, 32'hDEAD_BEEF);
    n = 0;
    while (tx_count < base + 3 && n < 40) begin @(negedge clk); n++; end
    tick();
    uart_txd_ready = 1'b0;
    saved_tx = tx_count;
    repeat (50) tick();
    checkOutput("ready_low_no_tx", tx_count, saved_tx);
    uart_txd_ready = 1'b1;
    n = 0;
    while (tx_count < base + 6 && n < 40) begin @(negedge clk); n++; end
    checkOutput("stall_reached_a3", tx_count, base + 6);
    tick();
    reset = 1'b1;
    tx_exp.delete();
    tick();
    reset = 1'b0;
    @(negedge clk);
    checkOutput("midrst_cmd_ready", cmd_ready, 0);
    checkOutput("midrst_busy", busy, 0);
    checkOutput("midrst_rd_data", rd_data, 0);
    checkOutput("midrst_done_error", {done, error, rd_strobe, wr_ready}, 0);
    checkOutput("midrst_txd", {uart_txd_strobe, uart_txd}, 0);
    saved_tx   = tx_count;
    saved_term = term_count;
    tick();
    repeat (20) tick();
    checkOutput("midrst_no_tx", tx_count, saved_tx);
    checkOutput("midrst_no_term", term_count, saved_term);
    applyStimulus(1'b0, 24'd1, 32'h0102_0304);
    wait_tx_drain("post_rst_hdr_drain", 40);
    send_rx(8'h21, 1'b1);
    wait_term("post_rst_read", 5, 1'b1);

    checkOutput("tx_queue_empty", tx_exp.size(), 0);
    checkOutput("rd_queue_empty", rd_exp.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
